// File: rtl/led_matrix_scanner.sv
// Read-side scanner for the 512x6 frame memory driving a 32x32 RGB panel with 1/16 scan.
// Sweeps {row,col}, shifts 32 columns per row, then blanks, latches and displays for DWELL cycles.
module led_matrix_scanner #(
  parameter int unsigned DWELL = 256
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] rd,
  output logic [8:0] adr,
  output logic [5:0] rgb,
  output logic       sclk,
  output logic       lat,
  output logic       oe_n,
  output logic [3:0] row_addr,
  output logic       frame_done
);

  localparam int unsigned ROW_W   = 4;
  localparam int unsigned COL_W   = 5;
  localparam int unsigned DWELL_W = 16;
  localparam int unsigned DATA_W  = 6;
  localparam int unsigned ADR_W   = ROW_W + COL_W;

  localparam logic [COL_W-1:0]   COL_LAST     = COL_W'(31);
  localparam logic [ROW_W-1:0]   ROW_LAST     = ROW_W'(15);
  localparam logic [DWELL_W-1:0] DWELL_RELOAD = DWELL_W'(DWELL - 1);

  typedef enum logic [2:0] {
    ST_SHIFT,
    ST_TAIL,
    ST_BLANK,
    ST_LATCH,
    ST_DISPLAY
  } state_e;

  state_e               state_q, state_d;
  logic                 phase_q, phase_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;

  logic [ADR_W-1:0]     adr_q, adr_d;
  logic [DATA_W-1:0]    rgb_q, rgb_d;
  logic                 sclk_q, sclk_d;
  logic                 lat_q, lat_d;
  logic                 oe_n_q, oe_n_d;
  logic [ROW_W-1:0]     row_addr_q, row_addr_d;
  logic                 frame_done_q, frame_done_d;
  logic                 enter_phase_b;

  // Next-state and next-output logic; every output reflects the state being entered.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    row_d         = row_q;
    col_d         = col_q;
    dwell_d       = dwell_q;
    enter_phase_b = 1'b0;

    case (state_q)
      ST_SHIFT: begin
        if (!phase_q) begin
          phase_d       = 1'b1;
          enter_phase_b = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (col_q == COL_LAST) begin
            col_d   = '0;
            state_d = ST_TAIL;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      ST_TAIL:  state_d = ST_BLANK;
      ST_BLANK: state_d = ST_LATCH;
      ST_LATCH: begin
        state_d = ST_DISPLAY;
        dwell_d = DWELL_RELOAD;
      end
      ST_DISPLAY: begin
        if (dwell_q == '0) begin
          state_d = ST_SHIFT;
          phase_d = 1'b0;
          row_d   = row_q + ROW_W'(1);
        end else begin
          dwell_d = dwell_q - DWELL_W'(1);
        end
      end
      default: begin
        state_d = ST_SHIFT;
        phase_d = 1'b0;
      end
    endcase

    adr_d        = {row_d, col_d};
    rgb_d        = enter_phase_b ? rd : rgb_q;
    // Column 0 gets no edge in SHIFT; its data is clocked by the following column's phase A.
    sclk_d       = ((state_d == ST_SHIFT) && !phase_d && (col_d != '0)) || (state_d == ST_TAIL);
    lat_d        = (state_d == ST_LATCH);
    oe_n_d       = (state_d != ST_DISPLAY);
    row_addr_d   = (state_d == ST_BLANK) ? row_q : row_addr_q;
    frame_done_d = (state_d == ST_DISPLAY) && (dwell_d == '0) && (row_q == ROW_LAST);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_SHIFT;
      phase_q      <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      dwell_q      <= '0;
      adr_q        <= '0;
      rgb_q        <= '0;
      sclk_q       <= 1'b0;
      lat_q        <= 1'b0;
      oe_n_q       <= 1'b1;
      row_addr_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      row_q        <= row_d;
      col_q        <= col_d;
      dwell_q      <= dwell_d;
      adr_q        <= adr_d;
      rgb_q        <= rgb_d;
      sclk_q       <= sclk_d;
      lat_q        <= lat_d;
      oe_n_q       <= oe_n_d;
      row_addr_q   <= row_addr_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign adr        = adr_q;
  assign rgb        = rgb_q;
  assign sclk       = sclk_q;
  assign lat        = lat_q;
  assign oe_n       = oe_n_q;
  assign row_addr   = row_addr_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/led_matrix_scanner.md
# led_matrix_scanner

Read-side scanner for the 512×6 game-board frame memory. It sweeps the memory addresses in row/column order and drives a 32×32 RGB LED panel with 1/16 scan: serial colour data, shift clock, latch, output enable and row address. It owns the memory's read address, never writes, and sits between the frame memory and the panel connector.

## Interface
- DWELL, 256: display cycles per row with oe_n low; legal range 1..65535.
- clk  input  1  system clock; the frame memory is clocked by the same clk.
- reset_n  input  1  asynchronous, active-low reset.
- rd  input  6  frame-memory read data. Registered by the memory on negedge clk from adr.
- adr  output  9  frame-memory read address, {row[3:0], col[4:0]}, registered.
- rgb  output  6  panel data {r1,g1,b1,r2,g2,b2}, registered.
- sclk  output  1  panel shift clock, registered.
- lat  output  1  panel latch, one-cycle high pulse.
- oe_n  output  1  panel output enable, active low.
- row_addr  output  4  panel row select.
- frame_done  output  1  one-cycle pulse at the end of each full frame.

## Operation
- Memory word at {r,c}:
  - rd[5:3] is the colour of panel pixel (row r, column c).
  - rd[2:0] is the colour of panel pixel (row r+16, column c).
- Counters: row (4 bits), col (5 bits), phase (1 bit), dwell counter (16 bits).
- adr always equals {row, col}.
- FSM states:
  - SHIFT: two cycles per column.
    - Phase A: sclk=1 if col>0, otherwise sclk=0. adr presents the current column.
    - Phase B: rgb<=rd at entry, sclk=0.
    - From phase B with col<31: col+1, phase A.
    - From phase B with col=31: go to TAIL.
  - TAIL: one cycle. sclk=1 clocks in column 31. col wraps to 0.
  - BLANK: one cycle. sclk=0, oe_n=1, row_addr<=row.
  - LATCH: one cycle. lat=1.
  - DISPLAY: DWELL cycles with oe_n=0.
    - On the last cycle, row increments; 15 wraps to 0.
    - frame_done=1 on the last cycle when row was 15.
    - Next state is SHIFT, phase A.
- oe_n is 1 in every state except DISPLAY.
- lat is 1 only in LATCH.
- rgb holds its value outside SHIFT phase-B entry.
- The panel sees exactly 32 sclk rising edges per row: 31 in SHIFT, 1 in TAIL. Each rising edge occurs with rgb stable for the full preceding cycle.
- The block free-runs forever. It has no enable or stall input.

## Timing
- Reset (asynchronous, immediate) values:
  - Outputs: adr=0, rgb=0, sclk=0, lat=0, oe_n=1, row_addr=0, frame_done=0.
  - Internal: state SHIFT, phase A, row=0, col=0, dwell counter=0.
- Read latency: adr set at posedge k → memory registers rd at the following negedge → rgb captures it at posedge k+1.
- Column c of row r:
  - rgb=mem[{r,c}] from the phase-B entry edge until the next phase-B entry edge.
  - sclk rises one cycle after rgb changes and stays high for one cycle.
- Row period: 64 (SHIFT) + 1 (TAIL) + 1 (BLANK) + 1 (LATCH) + DWELL cycles. At default DWELL this is 323 cycles.
- Frame period: 16 × row period, which is 5168 cycles at default DWELL.
- frame_done is high for exactly one cycle per frame, in the final DISPLAY cycle of row 15.
- The row_addr change happens only in BLANK, while oe_n=1. The panel never shows a mid-change row.
- DWELL=1 gives a single-cycle DISPLAY.
- The dwell counter reloads every row.
- Reset asserted mid-row:
  - All outputs return to reset values on the assertion edge.
  - A partial shift is discarded.
  - After release, scanning restarts at row 0, col 0.
- There is no write hazard. The block never drives the memory write enable, and concurrent writes by the game logic appear on the next read of that address.

## Test plan
- Reset values: hold reset_n=0 for 5 cycles, then release. Required: adr=0, rgb=0, sclk=0, lat=0, oe_n=1, row_addr=0, frame_done=0 through release. The first posedge after release captures rgb=mem[0].
- First-column timing, with a behavioural memory (mem[0]=6'h2A, mem[1]=6'h15):
  - rgb=6'h2A at edge 1 after release, sclk=0 at edge 1.
  - sclk=1 and adr=1 at edge 2.
  - rgb=6'h15 and sclk=0 at edge 3.
- Row shift count: across row 0, count sclk rising edges and record rgb at each one. Required: exactly 32 edges, values mem[0..31] in order, then lat high for exactly 1 cycle after the 32nd sclk falls.
- Blanking and dwell with DWELL=4:
  - oe_n=0 for exactly 4 consecutive cycles per row.
  - row_addr changes only while oe_n=1.
  - Row period is 71 cycles.
- Frame wrap with DWELL=4:
  - frame_done pulses once every 1136 cycles.
  - After row 15, adr returns to 0 and row_addr returns to 0.
  - Row 5 shifts data from addresses 160..191.
- Reset mid-operation: assert reset_n=0 during SHIFT of row 7, col 12. Required: outputs at reset values immediately; after release, adr=0 and the next lat occurs after row 0's 32 sclk edges.
